step_ramp_ctrl: RTL and testbench

Trapezoidal motion-profile sequencer for the stepper step-clock path. It accepts a move command (step count and direction) and drives the 28-bit divider value and reset of the downstream clock divider. It counts the rising edges of the divided step clock and ramps the divider down (accelerate), holds it (cruise), then ramps it back up (decelerate) so the move ends at the start rate. It sits between the command/register logic and the clock divider that feeds the phase sequencer.

---
 rtl/step_ramp_ctrl.sv | 141 ++++++++++++++
 tb/tb_step_ramp_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/step_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : step_ramp_ctrl
// Description : Trapezoidal motion-profile sequencer for the stepper step
//               clock. Accepts a move command (step count, direction) and
//               drives the downstream clock divider value and reset. The
//               divider ramps down (accelerate), holds (cruise), then ramps
//               back up (decelerate) so the move ends at the start rate.
// Ports       : n_CLK, n_RST      - clock, synchronous active-high reset
//               i_start/i_target/i_dir - move request, sampled in IDLE
//               i_abort           - stop the running move immediately
//               i_step_clk        - divided clock, one step per rising edge
//               o_divider/o_div_rst - divider value and divider reset
//               o_dir, o_busy, o_done, o_step_count - move status
// Revision    : 1.0 - initial release
// ============================================================================
module step_ramp_ctrl #(
    parameter logic [27:0] P_START = 28'd10,
    parameter logic [27:0] P_MIN   = 28'd4,
    parameter logic [27:0] P_DELTA = 28'd2,
    parameter int          CNT_W   = 16
) (
    input  logic             n_CLK,
    input  logic             n_RST,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_dir,
    input  logic             i_step_clk,
    output logic [27:0]      o_divider,
    output logic             o_div_rst,
    output logic             o_dir,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_step_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEL  = 3'd1;
    localparam logic [2:0] S_CRUISE = 3'd2;
    localparam logic [2:0] S_DECEL  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state, next_state;
    logic             step_q;
    logic [CNT_W-1:0] target, ramp_cnt;

    logic [27:0]      nxt_divider;
    logic [CNT_W-1:0] nxt_count, nxt_ramp, nxt_target;
    logic             nxt_dir;

    logic             step_edge;
    logic [CNT_W-1:0] n_cnt, rem;
    logic [28:0]      up_sum, accel_lim;

    assign step_edge = ~step_q & i_step_clk;
    assign n_cnt     = o_step_count + CNT_W'(1);
    assign rem       = target - n_cnt;
    // Both sums carry an extra bit so large parameters cannot wrap.
    assign up_sum    = {1'b0, o_divider} + {1'b0, P_DELTA};
    assign accel_lim = {1'b0, P_MIN} + {1'b0, P_DELTA};

    // State and datapath registers
    always_ff @(posedge n_CLK) begin
        if (n_RST) begin
            state        <= S_IDLE;
            step_q       <= 1'b0;
            o_divider    <= P_START;
            o_dir        <= 1'b0;
            o_step_count <= '0;
            ramp_cnt     <= '0;
            target       <= '0;
        end else begin
            state        <= next_state;
            step_q       <= i_step_clk;
            o_divider    <= nxt_divider;
            o_dir        <= nxt_dir;
            o_step_count <= nxt_count;
            ramp_cnt     <= nxt_ramp;
            target       <= nxt_target;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        next_state  = state;
        nxt_divider = o_divider;
        nxt_count   = o_step_count;
        nxt_ramp    = ramp_cnt;
        nxt_target  = target;
        nxt_dir     = o_dir;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    nxt_target  = i_target;
                    nxt_dir     = i_dir;
                    nxt_count   = '0;
                    nxt_ramp    = '0;
                    nxt_divider = P_START;
                    next_state  = (i_target == '0) ? S_DONE : S_ACCEL;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                // Abort wins over a coincident step edge; that edge is lost.
                if (i_abort) begin
                    next_state = S_DONE;
                end else if (step_edge) begin
                    nxt_count = n_cnt;
                    if (rem == '0) begin
                        next_state = S_DONE;
                    end else if (rem <= ramp_cnt) begin
                        // Remaining steps just cover the ramp taken on the
                        // way up, so start slowing down symmetrically.
                        next_state  = S_DECEL;
                        nxt_divider = (up_sum > {1'b0, P_START}) ? P_START : up_sum[27:0];
                        nxt_ramp    = (ramp_cnt == '0) ? '0 : ramp_cnt - CNT_W'(1);
                    end else if (state == S_ACCEL) begin
                        if ({1'b0, o_divider} <= accel_lim) begin
                            nxt_divider = P_MIN;
                            next_state  = S_CRUISE;
                        end else begin
                            nxt_divider = o_divider - P_DELTA;
                        end
                        nxt_ramp = ramp_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        o_busy    = (state != S_IDLE);
        o_done    = (state == S_DONE);
        o_div_rst = (state == S_IDLE) || (state == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_step_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_ramp_ctrl
// Description : Self-checking bench for step_ramp_ctrl: table of directed
//               vectors for full trapezoid and triangle moves, plus hand
//               sequences for reset, zero target, ignored start, abort and
//               reset during a move.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_ramp_ctrl;

    logic        n_CLK = 1'b0;
    logic        n_RST = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [15:0] i_target = '0;
    logic        i_dir = 1'b0;
    logic        i_step_clk = 1'b0;
    logic [27:0] o_divider;
    logic        o_div_rst, o_dir, o_busy, o_done;
    logic [15:0] o_step_count;

    int errors = 0;
    int checks = 0;

    step_ramp_ctrl dut (
        .n_CLK       (n_CLK),
        .n_RST       (n_RST),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_target    (i_target),
        .i_dir       (i_dir),
        .i_step_clk  (i_step_clk),
        .o_divider   (o_divider),
        .o_div_rst   (o_div_rst),
        .o_dir       (o_dir),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_step_count(o_step_count)
    );

    always #5 n_CLK = ~n_CLK;

    // op: 0 = start command, 1 = one step edge, 2 = one idle cycle
    typedef struct {
        int          op;
        logic [15:0] target;
        logic        dir;
        logic [27:0] exp_div;
        logic [15:0] exp_cnt;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_rst;
        logic        exp_dir;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(int op, logic [15:0] t, logic d, logic [27:0] dv,
                                logic [15:0] c, logic b, logic dn, logic r, logic ed);
        vec_t v;
        v.op = op; v.target = t; v.dir = d; v.exp_div = dv; v.exp_cnt = c;
        v.exp_busy = b; v.exp_done = dn; v.exp_rst = r; v.exp_dir = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Invariant: every task returns 1 time unit after a rising clock edge.
    task automatic tick();
        @(posedge n_CLK);
        #1;
    endtask

    task automatic do_start(input logic [15:0] t, input logic d);
        i_start = 1'b1; i_target = t; i_dir = d;
        tick();
        i_start = 1'b0;
    endtask

    // One low cycle so the edge detector sees a clean 0->1 transition.
    task automatic do_step();
        i_step_clk = 1'b0;
        tick();
        i_step_clk = 1'b1;
        tick();
        i_step_clk = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [27:0] dv, input logic [15:0] c,
                             input logic b, input logic dn, input logic r);
        check({tag, " divider"},    32'(o_divider),    32'(dv));
        check({tag, " step_count"}, 32'(o_step_count), 32'(c));
        check({tag, " busy"},       32'(o_busy),       32'(b));
        check({tag, " done"},       32'(o_done),       32'(dn));
        check({tag, " div_rst"},    32'(o_div_rst),    32'(r));
    endtask

    initial begin
        // Full trapezoid, target 8, dir 1
        vecs[0]  = mk(0, 16'd8, 1'b1, 28'd10, 16'd0, 1, 0, 0, 1);
        vecs[1]  = mk(1, 16'd0, 1'b0, 28'd8,  16'd1, 1, 0, 0, 1);
        vecs[2]  = mk(1, 16'd0, 1'b0, 28'd6,  16'd2, 1, 0, 0, 1);
        vecs[3]  = mk(1, 16'd0, 1'b0, 28'd4,  16'd3, 1, 0, 0, 1);
        vecs[4]  = mk(1, 16'd0, 1'b0, 28'd4,  16'd4, 1, 0, 0, 1);
        vecs[5]  = mk(1, 16'd0, 1'b0, 28'd6,  16'd5, 1, 0, 0, 1);
        vecs[6]  = mk(1, 16'd0, 1'b0, 28'd8,  16'd6, 1, 0, 0, 1);
        vecs[7]  = mk(1, 16'd0, 1'b0, 28'd10, 16'd7, 1, 0, 0, 1);
        vecs[8]  = mk(1, 16'd0, 1'b0, 28'd10, 16'd8, 1, 1, 1, 1);
        vecs[9]  = mk(2, 16'd0, 1'b0, 28'd10, 16'd8, 0, 0, 1, 1);
        // Triangle, target 3, dir 0
        vecs[10] = mk(0, 16'd3, 1'b0, 28'd10, 16'd0, 1, 0, 0, 0);
        vecs[11] = mk(1, 16'd0, 1'b0, 28'd8,  16'd1, 1, 0, 0, 0);
        vecs[12] = mk(1, 16'd0, 1'b0, 28'd10, 16'd2, 1, 0, 0, 0);
        vecs[13] = mk(1, 16'd0, 1'b0, 28'd10, 16'd3, 1, 1, 1, 0);
        vecs[14] = mk(2, 16'd0, 1'b0, 28'd10, 16'd3, 0, 0, 1, 0);
        vecs[15] = mk(2, 16'd0, 1'b0, 28'd10, 16'd3, 0, 0, 1, 0);

        // Reset held three cycles
        n_RST = 1'b1;
        repeat (3) tick();
        check_all("reset", 28'd10, 16'd0, 0, 0, 1);
        check("reset dir", 32'(o_dir), 32'd0);
        n_RST = 1'b0;
        tick();

        // Table-driven moves
        for (int i = 0; i < 16; i++) begin
            case (vecs[i].op)
                0:       do_start(vecs[i].target, vecs[i].dir);
                1:       do_step();
                default: tick();
            endcase
            check_all($sformatf("vec%0d", i), vecs[i].exp_div, vecs[i].exp_cnt,
                      vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_rst);
            check($sformatf("vec%0d dir", i), 32'(o_dir), 32'(vecs[i].exp_dir));
        end

        // Zero target: done next cycle, divider never released
        do_start(16'd0, 1'b1);
        check("zero done", 32'(o_done), 32'd1);
        check("zero div_rst", 32'(o_div_rst), 32'd1);
        check("zero busy", 32'(o_busy), 32'd1);
        tick();
        check("zero idle done", 32'(o_done), 32'd0);
        check("zero idle div_rst", 32'(o_div_rst), 32'd1);
        check("zero idle busy", 32'(o_busy), 32'd0);

        // Start pulse mid-move is ignored
        do_start(16'd8, 1'b1);
        repeat (4) do_step();
        do_start(16'd5, 1'b0);
        check("ign count", 32'(o_step_count), 32'd4);
        check("ign dir", 32'(o_dir), 32'd1);
        check("ign busy", 32'(o_busy), 32'd1);
        do_step();
        check_all("ign e5", 28'd6, 16'd5, 1, 0, 0);
        repeat (2) do_step();
        check_all("ign e7", 28'd10, 16'd7, 1, 0, 0);
        do_step();
        check_all("ign e8", 28'd10, 16'd8, 1, 1, 1);
        tick();

        // Abort coincident with the fifth edge
        do_start(16'd8, 1'b0);
        repeat (4) do_step();
        check("abort pre count", 32'(o_step_count), 32'd4);
        i_step_clk = 1'b0;
        tick();
        i_step_clk = 1'b1;
        i_abort = 1'b1;
        tick();
        i_step_clk = 1'b0;
        i_abort = 1'b0;
        check_all("abort", 28'd4, 16'd4, 1, 1, 1);
        tick();
        check_all("abort idle", 28'd4, 16'd4, 0, 0, 1);

        // Reset during cruise: no done pulse, then a clean new move
        do_start(16'd8, 1'b1);
        repeat (4) do_step();
        check("mid cruise div", 32'(o_divider), 32'd4);
        n_RST = 1'b1;
        tick();
        check_all("mid reset", 28'd10, 16'd0, 0, 0, 1);
        check("mid reset dir", 32'(o_dir), 32'd0);
        n_RST = 1'b0;
        tick();
        check("post reset done", 32'(o_done), 32'd0);
        do_start(16'd3, 1'b1);
        check_all("post start", 28'd10, 16'd0, 1, 0, 0);
        do_step();
        check_all("post e1", 28'd8, 16'd1, 1, 0, 0);
        do_step();
        check_all("post e2", 28'd10, 16'd2, 1, 0, 0);
        do_step();
        check_all("post e3", 28'd10, 16'd3, 1, 1, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
